// File: rtl/mmio_timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer: register offsets,
// CTRL field positions, MODE encodings and the FSM state encoding.
package mmio_timer_pkg;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] OFF_RSVD   = 2'd3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } timer_state_t;

    // Byte-lane merge of a bus write over an existing register value.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/mmio_timer.sv
// Memory-mapped countdown timer with one-shot / auto-reload modes and a
// maskable, registered interrupt request.
module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h00007F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        irq
);

    // Bus protocol: there is no handshake. A write is accepted on the posedge
    // where we & hit; a read is a pure combinational function of addr and the
    // current register contents, so rdata is valid in the same cycle.

    logic [3:0]   ctrl, ctrl_next;
    logic [31:0]  preset, count, count_next;
    logic         irq_flag, irq_flag_next;
    timer_state_t state, state_next;

    logic [1:0]   offset;
    logic         wr_ctrl, wr_preset;
    logic [31:0]  preset_wr_val, preset_eff;
    logic         en, auto_reload;
    logic         fsm_clr_en, flag_set, flag_clr_fsm;

    assign hit    = (addr[31:4] == BASE_ADDR[31:4]);
    assign offset = addr[3:2];

    assign wr_ctrl   = we & hit & (offset == OFF_CTRL) & byteen[0];
    assign wr_preset = we & hit & (offset == OFF_PRESET);

    assign preset_wr_val = merge_bytes(preset, wdata, byteen);
    // A PRESET write in the LOAD cycle is loaded straight into COUNT.
    assign preset_eff    = wr_preset ? preset_wr_val : preset;

    assign en          = ctrl[CTRL_EN];
    assign auto_reload = (ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);

    always_comb begin
        state_next   = state;
        count_next   = count;
        fsm_clr_en   = 1'b0;
        flag_set     = 1'b0;
        flag_clr_fsm = 1'b0;
        case (state)
            ST_IDLE: if (en) state_next = ST_LOAD;
            ST_LOAD: begin
                count_next = preset_eff;
                state_next = ST_CNT;
            end
            ST_CNT: begin
                if (!en) begin
                    state_next = ST_IDLE;
                end else if (count == 32'd0) begin
                    state_next = ST_INT;
                    flag_set   = 1'b1;
                end else begin
                    count_next = count - 32'd1;
                end
            end
            ST_INT: begin
                if (auto_reload) begin
                    state_next   = ST_LOAD;
                    flag_clr_fsm = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                    fsm_clr_en = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Bus writes take precedence over the FSM for both EN and the irq flag.
    always_comb begin
        ctrl_next = ctrl;
        if (fsm_clr_en) ctrl_next[CTRL_EN] = 1'b0;
        if (wr_ctrl)    ctrl_next = wdata[3:0];
    end

    always_comb begin
        irq_flag_next = irq_flag;
        if (wr_ctrl || flag_clr_fsm) irq_flag_next = 1'b0;
        else if (flag_set)           irq_flag_next = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            ctrl     <= 4'd0;
            preset   <= 32'd0;
            count    <= 32'd0;
            irq_flag <= 1'b0;
        end else begin
            state    <= state_next;
            ctrl     <= ctrl_next;
            count    <= count_next;
            irq_flag <= irq_flag_next;
            if (wr_preset) preset <= preset_wr_val;
        end
    end

    assign irq = irq_flag & ctrl[CTRL_IM];

    always_comb begin
        rdata = 32'd0;
        if (hit) begin
            case (offset)
                OFF_CTRL:   rdata = {28'd0, ctrl};
                OFF_PRESET: rdata = preset;
                OFF_COUNT:  rdata = count;
                OFF_RSVD:   rdata = 32'd0;
                default:    rdata = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_timer.sv
// Directed self-checking bench for mmio_timer: register access, one-shot and
// auto-reload timing, byte lanes, EN clear mid-count and asynchronous reset.
module tb_mmio_timer;

    localparam logic [31:0] BASE = 32'h00007F00;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        hit;
    logic        irq;

    int checks = 0;
    int errors = 0;

    mmio_timer #(.BASE_ADDR(BASE)) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .we     (we),
        .byteen (byteen),
        .wdata  (wdata),
        .rdata  (rdata),
        .hit    (hit),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called near a negedge; returns at the negedge after the write edge.
    task automatic bus_write(input logic [1:0] off, input logic [31:0] data, input logic [3:0] be);
        addr   = BASE | {28'd0, off, 2'b00};
        wdata  = data;
        byteen = be;
        we     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        we     = 1'b0;
        byteen = 4'd0;
    endtask

    task automatic check_reg(input string tag, input logic [1:0] off, input logic [31:0] exp);
        addr = BASE | {28'd0, off, 2'b00};
        #1;
        check(tag, rdata, exp);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset  = 1'b1;
        addr   = BASE;
        we     = 1'b0;
        byteen = 4'd0;
        wdata  = 32'd0;
        step(3);
        reset = 1'b0;
        step(1);

        // Reset state and address decode
        check_reg("rst_ctrl",   2'd0, 32'd0);
        check_reg("rst_preset", 2'd1, 32'd0);
        check_reg("rst_count",  2'd2, 32'd0);
        check_reg("rst_rsvd",   2'd3, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        addr = BASE + 32'h10;
        #1;
        check("miss_hit",   {31'd0, hit}, 32'd0);
        check("miss_rdata", rdata, 32'd0);

        // One-shot, PRESET = 5: INT entered 8 edges after the CTRL write
        bus_write(2'd1, 32'd5, 4'hF);
        bus_write(2'd0, 32'h9, 4'h1);
        step(2);
        check_reg("os_count5", 2'd2, 32'd5);
        for (int i = 4; i >= 0; i--) begin
            step(1);
            check_reg($sformatf("os_count%0d", i), 2'd2, i);
            check("os_irq_low", {31'd0, irq}, 32'd0);
        end
        step(1);
        check("os_irq_rise", {31'd0, irq}, 32'd1);
        step(1);
        check("os_irq_hold", {31'd0, irq}, 32'd1);
        check_reg("os_ctrl_en_cleared", 2'd0, 32'h8);
        step(3);
        check("os_irq_hold2", {31'd0, irq}, 32'd1);
        check_reg("os_count_floor", 2'd2, 32'd0);
        bus_write(2'd0, 32'h8, 4'h1);
        check("os_irq_clear", {31'd0, irq}, 32'd0);

        // Auto-reload, PRESET = 2: 1-cycle pulse every 5 cycles
        bus_write(2'd1, 32'd2, 4'hF);
        bus_write(2'd0, 32'hB, 4'h1);
        for (int k = 1; k <= 16; k++) begin
            step(1);
            check($sformatf("ar_irq_k%0d", k), {31'd0, irq}, (k % 5 == 0) ? 32'd1 : 32'd0);
        end
        check_reg("ar_ctrl_en_kept", 2'd0, 32'hB);
        bus_write(2'd0, 32'h0, 4'h1);
        step(5);

        // Byte lanes, read-only COUNT, reserved slot
        pulse_reset();
        bus_write(2'd1, 32'hAABBCCDD, 4'b0101);
        check_reg("be_preset", 2'd1, 32'h00BB00DD);
        bus_write(2'd2, 32'hFFFFFFFF, 4'hF);
        check_reg("count_ro", 2'd2, 32'd0);
        bus_write(2'd3, 32'h12345678, 4'hF);
        check_reg("rsvd_ro", 2'd3, 32'd0);
        addr = BASE + 32'h14;
        #1;
        check("miss_rdata2", rdata, 32'd0);

        // Clear EN mid-count: write issued while COUNT reads 7 lands as it
        // reaches 6, then the FSM drops to IDLE with COUNT frozen.
        pulse_reset();
        bus_write(2'd1, 32'd10, 4'hF);
        bus_write(2'd0, 32'h9, 4'h1);
        step(2);
        check_reg("frz_count10", 2'd2, 32'd10);
        step(3);
        check_reg("frz_count7", 2'd2, 32'd7);
        bus_write(2'd0, 32'h8, 4'h1);
        check_reg("frz_count6a", 2'd2, 32'd6);
        step(4);
        check_reg("frz_count6b", 2'd2, 32'd6);
        check("frz_irq", {31'd0, irq}, 32'd0);
        check_reg("frz_ctrl", 2'd0, 32'h8);
        bus_write(2'd0, 32'h9, 4'h1);
        step(2);
        check_reg("re_count10", 2'd2, 32'd10);
        step(1);
        check_reg("re_count9", 2'd2, 32'd9);

        // Asynchronous reset mid-count at COUNT = 3
        step(6);
        check_reg("pre_rst_count3", 2'd2, 32'd3);
        reset = 1'b1;
        #1;
        check_reg("arst_count", 2'd2, 32'd0);
        check_reg("arst_ctrl",  2'd0, 32'd0);
        check_reg("arst_preset", 2'd1, 32'd0);
        check("arst_irq", {31'd0, irq}, 32'd0);
        reset = 1'b0;
        step(3);
        check_reg("post_rst_count", 2'd2, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
